// File: rtl/ttt_move_controller.sv
// ttt_move_controller
//   Two-player tic-tac-toe controller driven by nine raw cell buttons.
//   Each button is debounced and rising-edge detected; the lowest-index
//   press in a cycle is taken as the move. Moves onto occupied cells are
//   rejected. After an accepted move a one-cycle CHECK state looks for a
//   completed line or a full board, then hands the turn over or ends the
//   game.
//
//   Ports
//     clk                : system clock, rising edge
//     reset              : synchronous active-high reset
//     buttons[8:0]       : raw buttons, bit0=a .. bit8=i, row-major
//     p1_turn / p2_turn  : player to move
//     p1_win / p2_win    : winner flags
//     grid_full          : draw (board full, no winner)
//     cell_p1 / cell_p2  : per-cell ownership for the board LEDs
//     move_valid         : one-cycle pulse, move accepted
//     move_reject        : one-cycle pulse, move onto an occupied cell
//     move_cell[3:0]     : cell of the last accepted/rejected move (holds)

// Per-button debouncer with registered rising-edge press pulse.
module ttt_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic press_o
);
  logic             db_q;
  logic             dbp_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      db_q    <= 1'b0;
      dbp_q   <= 1'b0;
      cnt_q   <= '0;
      press_o <= 1'b0;
    end else begin
      // Level must disagree for DEBOUNCE_CYCLES consecutive samples;
      // any agreeing sample restarts the count.
      if (raw_i != db_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_q  <= raw_i;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
      dbp_q   <= db_q;
      press_o <= db_q & ~dbp_q;
    end
  end
endmodule

module ttt_move_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] buttons,
  output logic       p1_turn,
  output logic       p2_turn,
  output logic       p1_win,
  output logic       p2_win,
  output logic       grid_full,
  output logic [8:0] cell_p1,
  output logic [8:0] cell_p2,
  output logic       move_valid,
  output logic       move_reject,
  output logic [3:0] move_cell
);

  typedef enum logic [1:0] {
    P1_WAIT   = 2'd0,
    P2_WAIT   = 2'd1,
    CHECK     = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  state_e     state_q;
  logic [8:0] press;

  for (genvar g = 0; g < 9; g++) begin : g_btn
    ttt_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (buttons[g]),
      .press_o (press[g])
    );
  end

  // Lowest-index press wins; the rest are simply dropped. Since presses
  // are edge pulses, a losing button that stays held never fires again.
  logic       pick_vld;
  logic [3:0] pick_idx;
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (press[i]) begin
        pick_vld = 1'b1;
        pick_idx = 4'(i);
      end
    end
  end

  logic [8:0] occ;
  logic [8:0] mover_board;
  assign occ         = cell_p1 | cell_p2;
  // During CHECK the turn flags still name the player who just moved.
  assign mover_board = p1_turn ? cell_p1 : cell_p2;

  function automatic logic has_line(input logic [8:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) |
           (b[6] & b[7] & b[8]) | (b[0] & b[3] & b[6]) |
           (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= P1_WAIT;
      p1_turn     <= 1'b1;
      p2_turn     <= 1'b0;
      p1_win      <= 1'b0;
      p2_win      <= 1'b0;
      grid_full   <= 1'b0;
      cell_p1     <= '0;
      cell_p2     <= '0;
      move_valid  <= 1'b0;
      move_reject <= 1'b0;
      move_cell   <= 4'd0;
    end else begin
      move_valid  <= 1'b0;
      move_reject <= 1'b0;
      case (state_q)
        P1_WAIT, P2_WAIT: begin
          if (pick_vld) begin
            move_cell <= pick_idx;
            if (occ[pick_idx]) begin
              move_reject <= 1'b1;
            end else begin
              if (state_q == P1_WAIT) cell_p1[pick_idx] <= 1'b1;
              else                    cell_p2[pick_idx] <= 1'b1;
              move_valid <= 1'b1;
              state_q    <= CHECK;
            end
          end
        end
        CHECK: begin
          if (has_line(mover_board)) begin
            if (p1_turn) p1_win <= 1'b1;
            else         p2_win <= 1'b1;
            p1_turn <= 1'b0;
            p2_turn <= 1'b0;
            state_q <= GAME_OVER;
          end else if (occ == 9'h1FF) begin
            grid_full <= 1'b1;
            p1_turn   <= 1'b0;
            p2_turn   <= 1'b0;
            state_q   <= GAME_OVER;
          end else begin
            p1_turn <= ~p1_turn;
            p2_turn <= p1_turn;
            state_q <= p1_turn ? P2_WAIT : P1_WAIT;
          end
        end
        GAME_OVER: ;
        default: state_q <= P1_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_move_controller.sv
module tb_ttt_move_controller;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] buttons;
  logic       p1_turn, p2_turn, p1_win, p2_win, grid_full;
  logic [8:0] cell_p1, cell_p2;
  logic       move_valid, move_reject;
  logic [3:0] move_cell;

  ttt_move_controller #(.DEBOUNCE_CYCLES(N), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .buttons(buttons),
    .p1_turn(p1_turn), .p2_turn(p2_turn), .p1_win(p1_win), .p2_win(p2_win),
    .grid_full(grid_full), .cell_p1(cell_p1), .cell_p2(cell_p2),
    .move_valid(move_valid), .move_reject(move_reject), .move_cell(move_cell)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: game described in terms of players, phases and lines.
  int         lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  logic [8:0] m_db, m_dbp, m_press;
  int         m_cnt [9];
  int         m_phase;   // 0 waiting for move, 1 checking, 2 game over
  int         m_mover;   // 1 or 2
  logic       m_t1, m_t2, m_w1, m_w2, m_full, m_v, m_r;
  logic [8:0] m_c1, m_c2;
  logic [3:0] m_cell;

  logic saw_v, saw_r;
  logic [3:0] saw_cell;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [8:0] raw);
    logic [8:0] np;
    logic [8:0] mb;
    int k;
    logic won;
    if (r) begin
      m_db = '0; m_dbp = '0; m_press = '0;
      for (int i = 0; i < 9; i++) m_cnt[i] = 0;
      m_phase = 0; m_mover = 1; m_t1 = 1; m_t2 = 0;
      m_w1 = 0; m_w2 = 0; m_full = 0; m_c1 = '0; m_c2 = '0;
      m_v = 0; m_r = 0; m_cell = 4'd0;
      return;
    end
    m_v = 0; m_r = 0;
    if (m_phase == 0) begin
      k = -1;
      for (int i = 8; i >= 0; i--) if (m_press[i]) k = i;
      if (k >= 0) begin
        m_cell = 4'(k);
        if (m_c1[k] || m_c2[k]) m_r = 1;
        else begin
          if (m_mover == 1) m_c1[k] = 1'b1; else m_c2[k] = 1'b1;
          m_v = 1; m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      mb = (m_mover == 1) ? m_c1 : m_c2;
      won = 0;
      for (int l = 0; l < 8; l++)
        if (mb[lines[l][0]] && mb[lines[l][1]] && mb[lines[l][2]]) won = 1;
      if (won) begin
        if (m_mover == 1) m_w1 = 1; else m_w2 = 1;
        m_t1 = 0; m_t2 = 0; m_phase = 2;
      end else if ((m_c1 | m_c2) == 9'h1FF) begin
        m_full = 1; m_t1 = 0; m_t2 = 0; m_phase = 2;
      end else begin
        m_mover = 3 - m_mover;
        m_t1 = (m_mover == 1); m_t2 = (m_mover == 2); m_phase = 0;
      end
    end
    for (int i = 0; i < 9; i++) np[i] = m_db[i] & ~m_dbp[i];
    m_press = np;
    m_dbp = m_db;
    for (int i = 0; i < 9; i++) begin
      if (raw[i] != m_db[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == N) begin m_db[i] = raw[i]; m_cnt[i] = 0; end
      end else m_cnt[i] = 0;
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {3'b0, p1_turn, p2_turn, p1_win, p2_win, grid_full, cell_p1, cell_p2,
            move_valid, move_reject, move_cell};
  endfunction

  function automatic logic [31:0] mdl_vec();
    return {3'b0, m_t1, m_t2, m_w1, m_w2, m_full, m_c1, m_c2, m_v, m_r, m_cell};
  endfunction

  task automatic step(input logic r, input logic [8:0] b);
    reset = r; buttons = b;
    @(posedge clk);
    model_step(r, b);
    #1;
    chk("cycle", dut_vec(), mdl_vec());
    chk("disjoint", {23'b0, cell_p1 & cell_p2}, 32'h0);
    if (move_valid)  begin saw_v = 1; saw_cell = move_cell; end
    if (move_reject) begin saw_r = 1; saw_cell = move_cell; end
  endtask

  task automatic do_reset();
    step(1'b1, 9'h0);
    chk("reset_vec", dut_vec(), {3'b0, 1'b1, 4'b0, 9'h0, 9'h0, 2'b0, 4'd0});
  endtask

  // Hold one button long enough to register, then release long enough to settle.
  task automatic mv(input int k);
    logic [8:0] m;
    m = 9'h0; m[k] = 1'b1;
    saw_v = 0; saw_r = 0;
    repeat (N + 2) step(1'b0, m);
    repeat (N + 2) step(1'b0, 9'h0);
  endtask

  initial begin
    logic [8:0] m;
    logic [31:0] snap;
    int len;
    int gap;
    reset = 1'b1; buttons = 9'h0;
    saw_v = 0; saw_r = 0; saw_cell = 0;

    // 1: first move latency
    do_reset();
    repeat (5) step(1'b0, 9'h001);
    chk("t1_no_early_valid", {31'b0, move_valid}, 32'd0);
    step(1'b0, 9'h001);
    chk("t1_valid", {31'b0, move_valid}, 32'd1);
    chk("t1_cell", {28'b0, move_cell}, 32'd0);
    chk("t1_board", {23'b0, cell_p1}, 32'h001);
    chk("t1_turn_hold", {30'b0, p1_turn, p2_turn}, 32'b10);
    step(1'b0, 9'h001);
    chk("t1_turn_swap", {30'b0, p1_turn, p2_turn}, 32'b01);
    repeat (N + 2) step(1'b0, 9'h0);

    // 2: P1 wins top row, then game over ignores input
    do_reset();
    mv(0); mv(3); mv(1); mv(5); mv(2);
    chk("t2_win", {29'b0, p1_win, p2_win, grid_full}, 32'b100);
    chk("t2_p1", {23'b0, cell_p1}, 32'h007);
    chk("t2_p2", {23'b0, cell_p2}, 32'h028);
    chk("t2_turns", {30'b0, p1_turn, p2_turn}, 32'b00);
    snap = dut_vec();
    mv(4);
    chk("t2_frozen", dut_vec(), snap);
    chk("t2_no_pulse", {30'b0, saw_v, saw_r}, 32'b00);

    // 3: short glitch is filtered
    do_reset();
    repeat (N - 1) step(1'b0, 9'h002);
    repeat (N + 4) step(1'b0, 9'h0);
    chk("t3_glitch", {28'b0, saw_v, p1_turn, cell_p1 == 9'h0, cell_p2 == 9'h0}, 32'b0111);

    // 4: reject onto occupied cell, then legal move
    do_reset();
    mv(0);
    mv(0);
    chk("t4_reject", {29'b0, saw_r, saw_v, p2_turn}, 32'b101);
    chk("t4_rej_cell", {28'b0, saw_cell}, 32'd0);
    chk("t4_board", {14'b0, cell_p1, cell_p2}, {14'b0, 9'h001, 9'h000});
    mv(4);
    chk("t4_accept", {31'b0, saw_v}, 32'd1);
    chk("t4_p2", {23'b0, cell_p2}, 32'h010);

    // 5: simultaneous c and e, lowest index wins; e held stays ignored
    do_reset();
    repeat (16) step(1'b0, 9'h014);
    repeat (N + 2) step(1'b0, 9'h0);
    chk("t5_board", {14'b0, cell_p1, cell_p2}, {14'b0, 9'h004, 9'h000});
    chk("t5_turn", {30'b0, p1_turn, p2_turn}, 32'b01);

    // 6: draw, then reset
    do_reset();
    mv(0); mv(1); mv(2); mv(4); mv(3); mv(5); mv(7); mv(6); mv(8);
    chk("t6_full", {29'b0, p1_win, p2_win, grid_full}, 32'b001);
    chk("t6_board", {14'b0, cell_p1, cell_p2}, {14'b0, 9'h18D, 9'h072});
    do_reset();

    // Randomized play against the model
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 39) == 0 || (m_phase == 2 && $urandom_range(0, 2) == 0))
        step(1'b1, 9'h0);
      m = 9'h0;
      m[$urandom_range(0, 8)] = 1'b1;
      if ($urandom_range(0, 5) == 0) m[$urandom_range(0, 8)] = 1'b1;
      len = $urandom_range(1, 8);
      gap = $urandom_range(0, 7);
      repeat (len) step(1'b0, m);
      repeat (gap) step(1'b0, 9'h0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
